// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
//
// Shares one AXI4 read master (AR/R channels) between NUM_REQ fetch units.
// Requests are granted round-robin. Only one burst is outstanding at a time.
// R beats are steered back to the granted requester with zero latency.
//
// Ports
//   aclk, aresetn                 clock, asynchronous active-low reset
//   req_valid/addr/len            per-requester burst request (flattened vectors)
//   req_ready                     one-hot pulse on the AR handshake of the winner
//   rd_data/rd_last               shared read data / last beat
//   rd_valid                      one-hot beat valid for the granted requester
//   rd_ready                      per-requester beat ready
//   m_ar*                         AXI4 read address channel (master side)
//   m_r*                          AXI4 read data channel (master side)
//   busy                          high while in the ADDR or DATA state
//   grant_idx                     current or last granted requester
//   len_err                       sticky: burst length did not match arlen
//   resp_err                      sticky: an rresp other than OKAY was seen
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int ID_W    = 3
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]      req_len,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_last,
    output logic [NUM_REQ-1:0]        rd_valid,
    input  logic [NUM_REQ-1:0]        rd_ready,
    output logic [ADDR_W-1:0]         m_araddr,
    output logic [7:0]                m_arlen,
    output logic [2:0]                m_arsize,
    output logic [1:0]                m_arburst,
    output logic [ID_W-1:0]           m_arid,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rlast,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_idx,
    output logic                      len_err,
    output logic                      resp_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    localparam logic [2:0] C_ARSIZE = 3'($clog2(DATA_W / 8));

    logic [1:0]         r_state;
    logic [ID_W-1:0]    r_grant;
    logic [ID_W-1:0]    r_last_grant;
    logic [7:0]         r_beat_cnt;
    logic               r_len_err;
    logic               r_resp_err;
    logic [ADDR_W-1:0]  r_addr;
    logic [7:0]         r_len;

    logic               w_any;
    logic [ID_W-1:0]    w_pick;
    logic [ADDR_W-1:0]  w_pick_addr;
    logic [7:0]         w_pick_len;
    logic [NUM_REQ-1:0] w_gnt_oh;
    logic               w_gnt_rdy;
    logic               w_ar_hs;
    logic               w_beat;

    // Round-robin pick: the pending requester with the smallest distance
    // above last_grant (wrapping) wins.
    always_comb begin : p_arb
        int v_best;
        int v_dist;
        v_best      = NUM_REQ;
        v_dist      = 0;
        w_any       = |req_valid;
        w_pick      = '0;
        w_pick_addr = '0;
        w_pick_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_dist = (i + 2 * NUM_REQ - 1 - int'(r_last_grant)) % NUM_REQ;
            if (req_valid[i] && (v_dist < v_best)) begin
                v_best      = v_dist;
                w_pick      = ID_W'(i);
                w_pick_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_pick_len  = req_len[i*8 +: 8];
            end
        end
    end

    always_comb begin
        w_gnt_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_gnt_oh[i] = (ID_W'(i) == r_grant);
        end
        w_gnt_rdy = |(rd_ready & w_gnt_oh);
    end

    assign w_ar_hs = (r_state == S_ADDR) && m_arready;
    assign w_beat  = (r_state == S_DATA) && m_rvalid && w_gnt_rdy;

    // Zero-latency steering; everything is gated by state so a reset
    // clears these outputs without waiting for a clock edge.
    assign m_arvalid = (r_state == S_ADDR);
    assign m_rready  = (r_state == S_DATA) && w_gnt_rdy;
    assign req_ready = w_ar_hs ? w_gnt_oh : '0;
    assign rd_valid  = ((r_state == S_DATA) && m_rvalid) ? w_gnt_oh : '0;
    assign rd_data   = m_rdata;
    assign rd_last   = m_rlast;

    assign m_araddr  = r_addr;
    assign m_arlen   = r_len;
    assign m_arid    = r_grant;
    assign m_arsize  = C_ARSIZE;
    assign m_arburst = 2'b01;

    assign busy      = (r_state != S_IDLE);
    assign grant_idx = r_grant;
    assign len_err   = r_len_err;
    assign resp_err  = r_resp_err;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_beat_cnt   <= '0;
            r_len_err    <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (m_arready) begin
                        r_beat_cnt <= '0;
                        r_state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        if (m_rresp != 2'b00) begin
                            r_resp_err <= 1'b1;
                        end
                        // Early rlast, or the expected last beat without rlast.
                        if (m_rlast != (r_beat_cnt == r_len)) begin
                            r_len_err <= 1'b1;
                        end
                        if (m_rlast) begin
                            r_last_grant <= r_grant;
                            r_state      <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Burst attributes are captured once at grant time and held until the
    // next grant, so the AR channel stays stable through any stall.
    always_ff @(posedge aclk) begin
        if ((r_state == S_IDLE) && w_any) begin
            r_addr <= w_pick_addr;
            r_len  <= w_pick_len;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int ID_W    = 3;

    logic                      aclk;
    logic                      aresetn;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*8-1:0]      req_len;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         rd_data;
    logic                      rd_last;
    logic [NUM_REQ-1:0]        rd_valid;
    logic [NUM_REQ-1:0]        rd_ready;
    logic [ADDR_W-1:0]         m_araddr;
    logic [7:0]                m_arlen;
    logic [2:0]                m_arsize;
    logic [1:0]                m_arburst;
    logic [ID_W-1:0]           m_arid;
    logic                      m_arvalid;
    logic                      m_arready;
    logic [DATA_W-1:0]         m_rdata;
    logic [1:0]                m_rresp;
    logic                      m_rlast;
    logic                      m_rvalid;
    logic                      m_rready;
    logic                      busy;
    logic [ID_W-1:0]           grant_idx;
    logic                      len_err;
    logic                      resp_err;

    logic [ADDR_W-1:0] ra [NUM_REQ];
    logic [7:0]        rl [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pack
        assign req_addr[gi*ADDR_W +: ADDR_W] = ra[gi];
        assign req_len[gi*8 +: 8]            = rl[gi];
    end

    axi_rd_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
        .req_ready(req_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arid(m_arid), .m_arvalid(m_arvalid),
        .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .busy(busy), .grant_idx(grant_idx), .len_err(len_err), .resp_err(resp_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One row per clock cycle of the contention scenario.
    typedef struct {
        logic [3:0] req_valid;
        logic       m_rvalid;
        logic [3:0] exp_req_ready;
        logic       exp_arvalid;
        logic [2:0] exp_gidx;
        logic [3:0] exp_rd_valid;
        logic       exp_rready;
        logic       exp_busy;
    } vec_t;

    vec_t vt [15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int cyc;
        logic pat;

        // All four requesters held with len=0: grants 0,1,2,3,0 with
        // IDLE -> ADDR -> DATA per burst.
        vt[0]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0};
        vt[1]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 3'd0, 4'b0000, 1'b0, 1'b1};
        vt[2]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b0001, 1'b1, 1'b1};
        vt[3]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0};
        vt[4]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 3'd1, 4'b0000, 1'b0, 1'b1};
        vt[5]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 3'd1, 4'b0010, 1'b1, 1'b1};
        vt[6]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 3'd1, 4'b0000, 1'b0, 1'b0};
        vt[7]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 3'd2, 4'b0000, 1'b0, 1'b1};
        vt[8]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 3'd2, 4'b0100, 1'b1, 1'b1};
        vt[9]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 3'd2, 4'b0000, 1'b0, 1'b0};
        vt[10] = '{4'hF, 1'b1, 4'b1000, 1'b1, 3'd3, 4'b0000, 1'b0, 1'b1};
        vt[11] = '{4'hF, 1'b1, 4'b0000, 1'b0, 3'd3, 4'b1000, 1'b1, 1'b1};
        vt[12] = '{4'hF, 1'b1, 4'b0000, 1'b0, 3'd3, 4'b0000, 1'b0, 1'b0};
        vt[13] = '{4'hF, 1'b1, 4'b0001, 1'b1, 3'd0, 4'b0000, 1'b0, 1'b1};
        vt[14] = '{4'hF, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b0001, 1'b1, 1'b1};

        aresetn   = 1'b0;
        req_valid = '0;
        rd_ready  = '1;
        m_arready = 1'b1;
        m_rdata   = '0;
        m_rresp   = 2'b00;
        m_rlast   = 1'b0;
        m_rvalid  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ra[i] = 32'h100 * i;
            rl[i] = 8'd0;
        end

        // ---------------- reset state ----------------
        repeat (2) @(negedge aclk);
        #1;
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_rready", m_rready, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_grant_idx", grant_idx, 0);
        chk("arsize", m_arsize, 3);
        chk("arburst", m_arburst, 1);
        @(negedge aclk);
        aresetn = 1'b1;

        // ---------------- contention table ----------------
        for (int i = 0; i < 15; i++) begin
            @(negedge aclk);
            req_valid = vt[i].req_valid;
            m_rvalid  = vt[i].m_rvalid;
            m_rlast   = 1'b1;
            #1;
            chk($sformatf("cont%0d_req_ready", i), req_ready, vt[i].exp_req_ready);
            chk($sformatf("cont%0d_arvalid", i), m_arvalid, vt[i].exp_arvalid);
            chk($sformatf("cont%0d_arid", i), m_arid, vt[i].exp_gidx);
            chk($sformatf("cont%0d_grant_idx", i), grant_idx, vt[i].exp_gidx);
            chk($sformatf("cont%0d_rd_valid", i), rd_valid, vt[i].exp_rd_valid);
            chk($sformatf("cont%0d_rready", i), m_rready, vt[i].exp_rready);
            chk($sformatf("cont%0d_busy", i), busy, vt[i].exp_busy);
        end
        @(negedge aclk);
        req_valid = '0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        #1;
        chk("cont_end_busy", busy, 0);

        // ---------------- single request, requester 2 ----------------
        @(negedge aclk);
        req_valid = 4'b0100;
        ra[2] = 32'h1000;
        rl[2] = 8'd3;
        #1;
        chk("single_idle_busy", busy, 0);
        @(negedge aclk);
        #1;
        chk("single_arvalid", m_arvalid, 1);
        chk("single_arid", m_arid, 2);
        chk("single_araddr", m_araddr, 32'h1000);
        chk("single_arlen", m_arlen, 3);
        chk("single_req_ready", req_ready, 4'b0100);
        for (int b = 0; b < 4; b++) begin
            @(negedge aclk);
            req_valid = '0;
            m_rvalid  = 1'b1;
            m_rdata   = 64'hA0 + 64'(b);
            m_rlast   = (b == 3);
            #1;
            chk($sformatf("single_b%0d_rd_valid", b), rd_valid, 4'b0100);
            chk($sformatf("single_b%0d_rd_data", b), rd_data, 64'hA0 + 64'(b));
            chk($sformatf("single_b%0d_rd_last", b), rd_last, (b == 3));
            chk($sformatf("single_b%0d_req_ready", b), req_ready, 0);
            chk($sformatf("single_b%0d_busy", b), busy, 1);
        end
        @(negedge aclk);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        #1;
        chk("single_end_busy", busy, 0);
        chk("single_end_rd_valid", rd_valid, 0);
        chk("single_end_rready", m_rready, 0);

        // ---------------- backpressure, requester 1, len 7 ----------------
        @(negedge aclk);
        req_valid = 4'b0010;
        ra[1] = 32'h2000;
        rl[1] = 8'd7;
        #1;
        @(negedge aclk);
        #1;
        chk("bp_arid", m_arid, 1);
        chk("bp_req_ready", req_ready, 4'b0010);
        k = 0;
        cyc = 0;
        while (k < 8 && cyc < 40) begin
            @(negedge aclk);
            req_valid = '0;
            pat       = (cyc % 3 == 0);
            rd_ready  = pat ? 4'b0010 : 4'b1101;
            m_rvalid  = 1'b1;
            m_rdata   = 64'hB0 + 64'(k);
            m_rlast   = (k == 7);
            #1;
            chk($sformatf("bp_c%0d_rready", cyc), m_rready, pat);
            chk($sformatf("bp_c%0d_rd_valid", cyc), rd_valid, 4'b0010);
            chk($sformatf("bp_c%0d_rd_data", cyc), rd_data, 64'hB0 + 64'(k));
            if (pat) k++;
            cyc++;
        end
        chk("bp_beats", 64'(k), 8);
        @(negedge aclk);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        rd_ready = '1;
        #1;
        chk("bp_end_busy", busy, 0);
        chk("bp_end_rd_valid", rd_valid, 0);
        chk("bp_len_err", len_err, 0);

        // ---------------- AR stall, requester 3 ----------------
        @(negedge aclk);
        req_valid = 4'b1000;
        ra[3] = 32'h3000;
        rl[3] = 8'd0;
        m_arready = 1'b0;
        #1;
        for (int s = 0; s < 5; s++) begin
            @(negedge aclk);
            if (s == 2) begin
                req_valid = 4'b1001;
                ra[0] = 32'h4000;
                rl[0] = 8'd3;
            end
            #1;
            chk($sformatf("stall%0d_arvalid", s), m_arvalid, 1);
            chk($sformatf("stall%0d_araddr", s), m_araddr, 32'h3000);
            chk($sformatf("stall%0d_arlen", s), m_arlen, 0);
            chk($sformatf("stall%0d_arid", s), m_arid, 3);
            chk($sformatf("stall%0d_req_ready", s), req_ready, 0);
        end
        @(negedge aclk);
        m_arready = 1'b1;
        #1;
        chk("stall_hs_req_ready", req_ready, 4'b1000);
        chk("stall_hs_arvalid", m_arvalid, 1);
        @(negedge aclk);
        req_valid = 4'b0001;
        m_rvalid  = 1'b1;
        m_rlast   = 1'b1;
        #1;
        chk("stall_data_arvalid", m_arvalid, 0);
        chk("stall_data_rd_valid", rd_valid, 4'b1000);

        // ---------------- length / response error, requester 0 ----------------
        @(negedge aclk);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        #1;
        chk("err_idle_busy", busy, 0);
        @(negedge aclk);
        #1;
        chk("err_arid", m_arid, 0);
        chk("err_araddr", m_araddr, 32'h4000);
        chk("err_arlen", m_arlen, 3);
        chk("err_req_ready", req_ready, 4'b0001);
        for (int b = 0; b < 3; b++) begin
            @(negedge aclk);
            req_valid = '0;
            m_rvalid  = 1'b1;
            m_rdata   = 64'hC0 + 64'(b);
            m_rlast   = (b == 2);
            m_rresp   = (b == 2) ? 2'b10 : 2'b00;
            #1;
            chk($sformatf("err_b%0d_rd_valid", b), rd_valid, 4'b0001);
            if (b == 0) chk("err_b0_len_err", len_err, 0);
        end
        @(negedge aclk);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rresp  = 2'b00;
        #1;
        chk("err_end_busy", busy, 0);
        chk("err_len_err", len_err, 1);
        chk("err_resp_err", resp_err, 1);

        // clean burst afterwards: flags stay set
        @(negedge aclk);
        req_valid = 4'b0010;
        ra[1] = 32'h5000;
        rl[1] = 8'd0;
        #1;
        @(negedge aclk);
        #1;
        chk("clean_arid", m_arid, 1);
        chk("clean_araddr", m_araddr, 32'h5000);
        @(negedge aclk);
        req_valid = '0;
        m_rvalid  = 1'b1;
        m_rlast   = 1'b1;
        #1;
        chk("clean_rd_valid", rd_valid, 4'b0010);
        @(negedge aclk);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        #1;
        chk("clean_busy", busy, 0);
        chk("clean_len_err", len_err, 1);
        chk("clean_resp_err", resp_err, 1);

        // ---------------- reset mid-burst, requester 2, len 7 ----------------
        @(negedge aclk);
        req_valid = 4'b0100;
        ra[2] = 32'h6000;
        rl[2] = 8'd7;
        #1;
        @(negedge aclk);
        #1;
        chk("mrst_arid", m_arid, 2);
        for (int b = 0; b < 3; b++) begin
            @(negedge aclk);
            req_valid = '0;
            m_rvalid  = 1'b1;
            m_rlast   = 1'b0;
            m_rdata   = 64'hD0 + 64'(b);
            #1;
            chk($sformatf("mrst_b%0d_rd_valid", b), rd_valid, 4'b0100);
        end
        #1;
        aresetn = 1'b0;
        #1;
        chk("mrst_rready", m_rready, 0);
        chk("mrst_rd_valid", rd_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_arvalid", m_arvalid, 0);
        chk("mrst_len_err", len_err, 0);
        chk("mrst_resp_err", resp_err, 0);
        chk("mrst_grant_idx", grant_idx, 0);
        @(negedge aclk);
        aresetn   = 1'b1;
        m_rvalid  = 1'b0;
        req_valid = 4'b1001;
        ra[0] = 32'h7000;
        ra[3] = 32'h8000;
        #1;
        chk("post_rst_idle_busy", busy, 0);
        @(negedge aclk);
        #1;
        chk("post_rst_arid", m_arid, 0);
        chk("post_rst_araddr", m_araddr, 32'h7000);
        chk("post_rst_req_ready", req_ready, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
